// File: rtl/branch_redirect_ctrl.sv
// Redirect controller between the EX branch unit and fetch: holds a redirect until fetch
// accepts it, kills wrong-path slots and raises misaligned-target exceptions. Optional BRU_STATS_EN.
module branch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int IALIGN       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bru_valid,
    input  logic        is_taken,
    input  logic [31:0] pc_bru,
    input  logic        if_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic        stall_req,
    output logic        misalign_exc,
    output logic [31:0] misalign_addr,
    output logic [31:0] br_count,
    output logic [31:0] br_taken_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REDIR = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] target_q, target_d;
    logic        exc_q, exc_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    logic        target_aligned;
    logic        accept_op;

    assign target_aligned = (IALIGN == 4) ? (pc_bru[1:0] == 2'b00) : (pc_bru[0] == 1'b0);

    // Only ops seen while IDLE are on the correct path; anything during REDIR/FLUSH is discarded.
    assign accept_op = (state_q == ST_IDLE) && bru_valid;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        exc_d      = 1'b0;
        exc_addr_d = exc_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_op && is_taken) begin
                    if (target_aligned) begin
                        target_d = pc_bru;
                        state_d  = ST_REDIR;
                    end else begin
                        exc_d      = 1'b1;
                        exc_addr_d = pc_bru;
                    end
                end
            end
            ST_REDIR: begin
                if (if_ready) begin
                    if (FLUSH_CYCLES == 1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                // The tail lasts FLUSH_CYCLES-1 cycles: leave as the counter reaches zero.
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            target_q   <= 32'd0;
            exc_q      <= 1'b0;
            exc_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            exc_q      <= exc_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    assign redirect_valid = (state_q == ST_REDIR);
    assign redirect_pc    = target_q;
    assign flush_if       = (state_q == ST_REDIR) || (state_q == ST_FLUSH);
    assign flush_id       = (state_q == ST_REDIR);
    assign stall_req      = (state_q == ST_REDIR);
    assign misalign_exc   = exc_q;
    assign misalign_addr  = exc_addr_q;

`ifdef BRU_STATS_EN
    logic [31:0] br_count_q;
    logic [31:0] br_taken_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q       <= 32'd0;
            br_taken_count_q <= 32'd0;
        end else if (accept_op) begin
            br_count_q <= br_count_q + 32'd1;
            if (is_taken) begin
                br_taken_count_q <= br_taken_count_q + 32'd1;
            end
        end
    end

    assign br_count       = br_count_q;
    assign br_taken_count = br_taken_count_q;
`else
    assign br_count       = 32'd0;
    assign br_taken_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench: two instances (FLUSH_CYCLES=2/IALIGN=4 and FLUSH_CYCLES=3/IALIGN=2)
// share one stimulus stream and are compared every cycle against a transaction-level model.
module tb_branch_redirect_ctrl;

    localparam int FC0 = 2;
    localparam int IA0 = 4;
    localparam int FC1 = 3;
    localparam int IA1 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bru_valid = 1'b0;
    logic        is_taken = 1'b0;
    logic [31:0] pc_bru = 32'd0;
    logic        if_ready = 1'b0;

    logic        rv0, fi0, fd0, st0, me0;
    logic [31:0] rp0, ma0, bc0, btc0;
    logic        rv1, fi1, fd1, st1, me1;
    logic [31:0] rp1, ma1, bc1, btc1;

    int tests_run = 0;
    int tests_failed = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.FLUSH_CYCLES(FC0), .IALIGN(IA0)) u_dut0 (
        .clk(clk), .rst(rst), .bru_valid(bru_valid), .is_taken(is_taken), .pc_bru(pc_bru),
        .if_ready(if_ready), .redirect_valid(rv0), .redirect_pc(rp0), .flush_if(fi0),
        .flush_id(fd0), .stall_req(st0), .misalign_exc(me0), .misalign_addr(ma0),
        .br_count(bc0), .br_taken_count(btc0)
    );

    branch_redirect_ctrl #(.FLUSH_CYCLES(FC1), .IALIGN(IA1)) u_dut1 (
        .clk(clk), .rst(rst), .bru_valid(bru_valid), .is_taken(is_taken), .pc_bru(pc_bru),
        .if_ready(if_ready), .redirect_valid(rv1), .redirect_pc(rp1), .flush_if(fi1),
        .flush_id(fd1), .stall_req(st1), .misalign_exc(me1), .misalign_addr(ma1),
        .br_count(bc1), .br_taken_count(btc1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pending redirect, a count of remaining wrong-path tail slots, an exception pulse.
    bit          m_pend [2];
    logic [31:0] m_pc   [2];
    int          m_tail [2];
    bit          m_exc  [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_cnt  [2];
    logic [31:0] m_tcnt [2];

    function automatic int fc_of(input int k);
        return (k == 0) ? FC0 : FC1;
    endfunction

    function automatic int ia_of(input int k);
        return (k == 0) ? IA0 : IA1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k] = 1'b0; m_pc[k] = 32'd0; m_tail[k] = 0;
                m_exc[k]  = 1'b0; m_addr[k] = 32'd0; m_cnt[k] = 32'd0; m_tcnt[k] = 32'd0;
            end else begin
                m_exc[k] = 1'b0;
                if (m_pend[k]) begin
                    if (if_ready) begin
                        m_pend[k] = 1'b0;
                        m_tail[k] = fc_of(k) - 1;
                    end
                end else if (m_tail[k] > 0) begin
                    m_tail[k]--;
                end else if (bru_valid) begin
                    m_cnt[k]++;
                    if (is_taken) begin
                        m_tcnt[k]++;
                        if ((pc_bru % 32'(ia_of(k))) == 32'd0) begin
                            m_pend[k] = 1'b1;
                            m_pc[k]   = pc_bru;
                        end else begin
                            m_exc[k]  = 1'b1;
                            m_addr[k] = pc_bru;
                        end
                    end
                end
            end
        end
    end

    task automatic cmp_dut(input int k, input logic rv, input logic [31:0] rp, input logic fi,
                           input logic fd, input logic st, input logic me, input logic [31:0] ma,
                           input logic [31:0] bc, input logic [31:0] btc);
        string p;
        p = (k == 0) ? "d0" : "d1";
        check({p, ".redirect_valid"}, 32'(rv), 32'(m_pend[k]));
        check({p, ".redirect_pc"}, rp, m_pc[k]);
        check({p, ".flush_if"}, 32'(fi), 32'(m_pend[k] || (m_tail[k] > 0)));
        check({p, ".flush_id"}, 32'(fd), 32'(m_pend[k]));
        check({p, ".stall_req"}, 32'(st), 32'(m_pend[k]));
        check({p, ".misalign_exc"}, 32'(me), 32'(m_exc[k]));
        if (m_exc[k]) check({p, ".misalign_addr"}, ma, m_addr[k]);
`ifdef BRU_STATS_EN
        check({p, ".br_count"}, bc, m_cnt[k]);
        check({p, ".br_taken_count"}, btc, m_tcnt[k]);
`else
        check({p, ".br_count"}, bc, 32'd0);
        check({p, ".br_taken_count"}, btc, 32'd0);
`endif
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp_dut(0, rv0, rp0, fi0, fd0, st0, me0, ma0, bc0, btc0);
            cmp_dut(1, rv1, rp1, fi1, fd1, st1, me1, ma1, bc1, btc1);
        end
    end

    // Drive inputs for the coming cycle, then land 1 time unit after the edge.
    task automatic step(input logic bv, input logic tk, input logic [31:0] pc, input logic rdy);
        bru_valid = bv;
        is_taken  = tk;
        pc_bru    = pc;
        if_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        check_en = 1'b1;
        step(1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;

        // Reset state
        check("rst.redirect_valid", 32'(rv0), 32'd0);
        check("rst.redirect_pc", rp0, 32'd0);
        check("rst.flush_if", 32'(fi0 | fi1), 32'd0);
        check("rst.misalign_addr", ma0, 32'd0);
        check("rst.br_count", bc0, 32'd0);

        // Taken aligned with fetch ready
        step(1'b1, 1'b1, 32'h100, 1'b1);
        check("t1.redirect_valid", 32'(rv0), 32'd1);
        check("t1.redirect_pc", rp0, 32'h100);
        check("t1.stall_req", 32'(st0), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("t2.redirect_valid", 32'(rv0), 32'd0);
        check("t2.flush_if", 32'(fi0), 32'd1);
        check("t2.flush_id", 32'(fd0), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("t3.flush_if_d0", 32'(fi0), 32'd0);
        check("t3.flush_if_d1", 32'(fi1), 32'd1);
        idle(2);

        // Fetch backpressure for three cycles
        step(1'b1, 1'b1, 32'h100, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check("bp4.redirect_valid", 32'(rv0), 32'd1);
        check("bp4.redirect_pc", rp0, 32'h100);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("bp5.redirect_valid", 32'(rv0), 32'd0);
        check("bp5.flush_if", 32'(fi0), 32'd1);
        idle(4);

        // Misaligned target: exception at IALIGN=4, redirect at IALIGN=2
        step(1'b1, 1'b1, 32'h102, 1'b1);
        check("mis.exc_d0", 32'(me0), 32'd1);
        check("mis.addr_d0", ma0, 32'h102);
        check("mis.rv_d0", 32'(rv0), 32'd0);
        check("mis.rv_d1", 32'(rv1), 32'd1);
        check("mis.pc_d1", rp1, 32'h102);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("mis.exc_gone_d0", 32'(me0), 32'd0);
        idle(4);

        // Wrong-path ops during REDIR and FLUSH are ignored
        step(1'b1, 1'b1, 32'h100, 1'b0);
        step(1'b1, 1'b1, 32'h200, 1'b0);
        check("wp.pc_held", rp0, 32'h100);
        step(1'b1, 1'b1, 32'h200, 1'b1);
        step(1'b1, 1'b1, 32'h200, 1'b1);
        check("wp.tail_rv", 32'(rv0), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("wp.idle_rv", 32'(rv0), 32'd0);
        check("wp.target", rp0, 32'h100);
        idle(4);

        // Reset in the middle of a stalled redirect
        step(1'b1, 1'b1, 32'h300, 1'b0);
        check("rr.rv_before", 32'(rv0), 32'd1);
        rst = 1'b1;
        step(1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;
        check("rr.rv_after", 32'(rv0 | rv1), 32'd0);
        check("rr.pc_after", rp0, 32'd0);
        check("rr.stall_after", 32'(st0), 32'd0);
        idle(3);
        check("rr.no_late_redirect", 32'(rv0 | rv1), 32'd0);

        // Back-to-back: new branch in the first IDLE cycle after FLUSH
        step(1'b1, 1'b1, 32'h400, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 32'h500, 1'b1);
        check("b2b.rv", 32'(rv0), 32'd1);
        check("b2b.pc", rp0, 32'h500);
        idle(5);

        // Statistics: five ops in IDLE, three taken (one of them misaligned at IALIGN=4)
        rst = 1'b1;
        step(1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b0, 32'h10, 1'b1);
        step(1'b1, 1'b1, 32'h600, 1'b1);
        idle(4);
        step(1'b1, 1'b0, 32'h20, 1'b1);
        step(1'b1, 1'b1, 32'h602, 1'b1);
        idle(4);
        step(1'b1, 1'b1, 32'h700, 1'b1);
        idle(4);
`ifdef BRU_STATS_EN
        check("stats.br_count", bc0, 32'd5);
        check("stats.br_taken_count", btc0, 32'd3);
`else
        check("stats.br_count", bc0, 32'd0);
        check("stats.br_taken_count", btc0, 32'd0);
`endif

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Branch/jump redirect controller placed between the EX-stage branch unit and the fetch stage. It captures every taken branch or jump resolved in EX and drives a held redirect request to fetch until fetch accepts it. It also kills wrong-path instructions in IF/ID and ID/EX for a configurable number of cycles and stalls EX while a redirect is pending. Misaligned targets raise an exception instead of a redirect.

## Interface
Parameters:
- FLUSH_CYCLES, 2: wrong-path fetch slots killed after fetch accepts the redirect; legal 1..3.
- IALIGN, 4: instruction alignment in bytes; 4 checks target[1:0], 2 checks target[0].

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- bru_valid  in  1  EX holds a resolved branch-unit op this cycle (bru_en & ~stall)
- is_taken  in  1  branch/jump taken; sampled only with bru_valid
- pc_bru  in  32  resolved target address
- if_ready  in  1  fetch accepts redirect this cycle
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- flush_if  out  1  kill IF/ID register contents
- flush_id  out  1  kill ID/EX register contents
- stall_req  out  1  hold EX and earlier stages
- misalign_exc  out  1  one-cycle misaligned-target exception pulse
- misalign_addr  out  32  offending target, valid with misalign_exc
- br_count  out  32  resolved branch ops (BRU_STATS_EN only)
- br_taken_count  out  32  taken branch ops (BRU_STATS_EN only)

## Operation
- States: IDLE, REDIR, FLUSH. A 2-bit down-counter cnt is used in FLUSH.
- IDLE:
  - bru_valid & is_taken & target aligned: capture pc_bru into target register, go to REDIR.
  - bru_valid & is_taken & misaligned: no redirect; next cycle misalign_exc=1 for one cycle with misalign_addr=pc_bru; remain IDLE.
  - bru_valid & ~is_taken: no action.
- REDIR:
  - Outputs: redirect_valid=1, redirect_pc=target, flush_if=1, flush_id=1, stall_req=1.
  - Held unchanged until if_ready=1.
  - On if_ready, go to FLUSH with cnt=FLUSH_CYCLES-1; if FLUSH_CYCLES=1, go to IDLE.
- FLUSH:
  - Outputs: flush_if=1, other control outputs 0.
  - cnt decrements each cycle; go to IDLE when cnt=0.
- bru_valid in REDIR or FLUSH is wrong-path: ignored, uncounted, no exception.
- redirect_pc always equals the target register, so it is stable for the whole REDIR period.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Reset: state=IDLE, target=0, all outputs 0 (including misalign_addr and counters).

## Timing
- Taken branch at edge T: redirect_valid, flush_if, flush_id and stall_req are high in cycle T+1.
- if_ready high in T+1: flush_if alone stays high for cycles T+2..T+1+(FLUSH_CYCLES-1); the block is IDLE again at T+1+FLUSH_CYCLES.
- With if_ready low, REDIR extends by one cycle per low cycle; no cap.
- Back-to-back: a taken branch in the first IDLE cycle after FLUSH is accepted normally.
- Misaligned: misalign_exc only in cycle T+1; it never overlaps redirect_valid.
- rst asserted in any state, mid-REDIR included: IDLE and all-zero outputs at the next edge; the pending redirect is dropped.

## Configuration
- BRU_STATS_EN defined:
  - br_count increments on every bru_valid accepted in IDLE.
  - br_taken_count increments when that op is taken, aligned or not.
  - Both wrap at 2^32 and clear on rst.
- BRU_STATS_EN undefined: counter registers and logic are not built; both ports are tied to 0.

## Test plan
- Taken aligned, FLUSH_CYCLES=2: bru_valid=1, is_taken=1, pc_bru=0x0000_0100 at T with if_ready=1 -> redirect_valid=1 and redirect_pc=0x100 in T+1 only; flush_if=1 for T+1..T+2; IDLE at T+3.
- Fetch backpressure: same stimulus with if_ready=0 for 3 cycles -> redirect_valid, stall_req, flush_if and flush_id high for T+1..T+4 with redirect_pc stable at 0x100; flush tail follows.
- Misaligned: pc_bru=0x0000_0102, IALIGN=4 -> misalign_exc=1 and misalign_addr=0x102 in T+1 only; redirect_valid stays 0. With IALIGN=2 the same input redirects.
- Wrong-path suppression: taken branch, then bru_valid=1 and is_taken=1 with pc_bru=0x200 during REDIR/FLUSH -> target stays 0x100, no second redirect, counters (if built) unchanged.
- Reset mid-REDIR: rst=1 for one cycle while if_ready=0 -> all outputs 0 next cycle, state IDLE, no later redirect.
- Stats, BRU_STATS_EN defined: 5 branches in IDLE, 3 of them taken -> br_count=5, br_taken_count=3. Undefined: both read 0.
